// File: rtl/dense_argmax.sv
// dense_argmax: streams CLASS_COUNT signed scores over a valid/ready handshake
// and reports the index and value of the largest one (ties keep the lower
// index). The result is held until the host acknowledges it.
module dense_argmax #(
  parameter int unsigned CLASS_COUNT = 10,
  parameter int unsigned DATA_SIZE   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [DATA_SIZE-1:0]           dataIn,
  input  logic                           dataValid,
  output logic                           ready,
  output logic                           busy,
  output logic                           done,
  input  logic                           ack,
  output logic [$clog2(CLASS_COUNT)-1:0] classIdx,
  output logic [DATA_SIZE-1:0]           maxValue
);

  localparam int unsigned IDX_W = $clog2(CLASS_COUNT);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CLASS_COUNT - 1);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [IDX_W-1:0] cnt_q;

  logic xfer_c;
  logic last_c;
  logic greater_c;

  assign xfer_c    = dataValid && (state_q == S_COLLECT);
  assign last_c    = (cnt_q == LAST_IDX);
  assign greater_c = $signed(dataIn) > $signed(maxValue);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start)           state_d = S_COLLECT;
      S_COLLECT: if (xfer_c && last_c) state_d = S_DONE;
      S_DONE:    if (ack)             state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  // Status outputs registered from the next state so they track state_q exactly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      ready <= (state_d == S_COLLECT);
      busy  <= (state_d == S_COLLECT) || (state_d == S_DONE);
      done  <= (state_d == S_DONE);
    end
  end

  // Sample counter and running maximum; sample 0 always reloads the result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      classIdx <= '0;
      maxValue <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      cnt_q <= '0;
    end else if (xfer_c) begin
      if ((cnt_q == '0) || greater_c) begin
        maxValue <= dataIn;
        classIdx <= cnt_q;
      end
      if (!last_c) begin
        cnt_q <= cnt_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dense_argmax.sv
// Directed bench for dense_argmax: table of score vectors plus hand-written
// reset, stall-free idle and handshake sequences.
module tb_dense_argmax;

  localparam int unsigned CC = 10;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = $clog2(CC);

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] dataIn;
  logic          dataValid;
  logic          ready;
  logic          busy;
  logic          done;
  logic          ack;
  logic [IW-1:0] classIdx;
  logic [DW-1:0] maxValue;

  dense_argmax #(.CLASS_COUNT(CC), .DATA_SIZE(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dataIn    (dataIn),
    .dataValid (dataValid),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .ack       (ack),
    .classIdx  (classIdx),
    .maxValue  (maxValue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    scores[CC];
    int    stall[CC];   // idle cycles inserted before sample k
    int    exp_idx;
    int    exp_max;
  } vec_t;

  vec_t vecs[7];
  int   n_tests;
  int   n_fail;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int smax();
    return int'($signed(maxValue));
  endfunction

  // Start an inference and stream all scores; leaves the DUT in DONE.
  task automatic stream_to_done(input vec_t v, output int cyc);
    cyc = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); cyc++;
    @(negedge clk);
    start = 1'b0;
    check({v.name, " ready_after_start"}, int'(ready), 1);
    check({v.name, " busy_after_start"}, int'(busy), 1);
    for (int k = 0; k < int'(CC); k++) begin
      for (int s = 0; s < v.stall[k]; s++) begin
        dataValid = 1'b0;
        dataIn    = 16'h7fff;  // must not be captured while stalled
        @(posedge clk); cyc++;
        @(negedge clk);
      end
      dataValid = 1'b1;
      dataIn    = DW'(v.scores[k]);
      @(posedge clk); cyc++;
      @(negedge clk);
      if (k == int'(CC) - 2) check({v.name, " done_before_last"}, int'(done), 0);
    end
    dataValid = 1'b0;
    dataIn    = '0;
    check({v.name, " done_after_last"}, int'(done), 1);
    check({v.name, " ready_in_done"}, int'(ready), 0);
    check({v.name, " classIdx"}, int'(classIdx), v.exp_idx);
    check({v.name, " maxValue"}, smax(), v.exp_max);
  endtask

  // Full inference; the host acknowledges one cycle after it sees done.
  task automatic run_vec(input vec_t v);
    int cyc;
    int stalls;
    stalls = 0;
    for (int k = 0; k < int'(CC); k++) stalls += v.stall[k];
    stream_to_done(v, cyc);
    @(posedge clk); cyc++;
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk); cyc++;
    @(negedge clk);
    ack = 1'b0;
    check({v.name, " done_after_ack"}, int'(done), 0);
    check({v.name, " busy_after_ack"}, int'(busy), 0);
    check({v.name, " cycles"}, cyc, int'(CC) + 3 + stalls);
  endtask

  initial begin
    int cyc;
    int bad;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b0;
    start     = 1'b0;
    ack       = 1'b0;
    dataValid = 1'b0;
    dataIn    = '0;

    vecs[0] = '{name: "basic", scores: '{3, -7, 12, 5, 40, -1, 0, 39, 2, 8},
                stall: '{default: 0}, exp_idx: 4, exp_max: 40};
    vecs[1] = '{name: "ties_neg", scores: '{-5, -2, -2, -9, -2, -100, -3, -4, -6, -8},
                stall: '{default: 0}, exp_idx: 1, exp_max: -2};
    vecs[2] = '{name: "all_min", scores: '{default: -32768},
                stall: '{default: 0}, exp_idx: 0, exp_max: -32768};
    vecs[3] = '{name: "stalls", scores: '{3, -7, 12, 5, 40, -1, 0, 39, 2, 8},
                stall: '{0, 0, 0, 3, 0, 0, 0, 0, 3, 0}, exp_idx: 4, exp_max: 40};
    vecs[4] = '{name: "win9", scores: '{1, 2, 3, 4, 5, 6, 7, 8, 9, 1000},
                stall: '{default: 0}, exp_idx: 9, exp_max: 1000};
    vecs[5] = '{name: "win0", scores: '{50, -1, 49, 50, 0, -32768, 7, 50, 3, 2},
                stall: '{default: 0}, exp_idx: 0, exp_max: 50};
    vecs[6] = '{name: "max_pos", scores: '{-32768, 0, 1, -1, 100, 32767, 32767, 5, -2, 32766},
                stall: '{default: 0}, exp_idx: 5, exp_max: 32767};

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset ready", int'(ready), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset classIdx", int'(classIdx), 0);
    check("reset maxValue", smax(), 0);

    // Reset mid-COLLECT after 4 transfers
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dataValid = 1'b1;
      dataIn    = DW'(60 + k);
      @(posedge clk);
      @(negedge clk);
    end
    dataValid = 1'b0;
    check("pre_reset maxValue", smax(), 63);
    rst = 1'b0;
    #1;
    check("midreset ready", int'(ready), 0);
    check("midreset busy", int'(busy), 0);
    check("midreset done", int'(done), 0);
    check("midreset classIdx", int'(classIdx), 0);
    check("midreset maxValue", smax(), 0);
    @(negedge clk);
    rst = 1'b1;

    // dataValid without start is ignored
    bad = 0;
    dataValid = 1'b1;
    dataIn    = DW'(1234);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready !== 1'b0 || busy !== 1'b0 || maxValue !== '0) bad++;
    end
    dataValid = 1'b0;
    check("idle_ignores_data", bad, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Hold in DONE with ack low; start pulses must be ignored
    stream_to_done(vecs[0], cyc);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i % 5 == 0);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (done !== 1'b1 || busy !== 1'b1 || ready !== 1'b0 ||
          int'(classIdx) != 4 || smax() != 40) bad++;
    end
    check("hold_stable", bad, 0);
    ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ack = 1'b0;
    check("ack done_falls", int'(done), 0);
    check("result_kept_in_idle", smax(), 40);

    // start and ack together in DONE: back to IDLE, start not latched
    stream_to_done(vecs[1], cyc);
    start = 1'b1;
    ack   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ack   = 1'b0;
    check("start_ack done", int'(done), 0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (ready !== 1'b0 || busy !== 1'b0) bad++;
      @(posedge clk);
      @(negedge clk);
    end
    check("start_ack no_ready", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
